// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: fetch FSM states,
// flush value and PC alignment helpers.
package if_fetch_unit_pkg;

  localparam int PC_WIDTH = 32;

  // Value loaded into IR/PC when the output buffer is flushed
  localparam logic [PC_WIDTH-1:0] NOP_INSTR = 32'h0;

  // Instruction addresses are word aligned
  localparam logic [PC_WIDTH-1:0] ADDR_ALIGN_MASK = 32'hFFFF_FFFC;

  // FETCH: request in flight or about to be issued
  // IDLE: buffer full, waiting for ID to take it
  // DISCARD: finishing a request whose data is no longer wanted
  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    IDLE    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_t;

  function automatic logic [PC_WIDTH-1:0] align_pc(input logic [PC_WIDTH-1:0] pc);
    return pc & ADDR_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/if_fetch_unit_out_buf.sv
// One-entry IR/PC/valid holding buffer feeding the IF/ID register.
// Priority: clear (flush) > load (new instruction) > consume (transfer).
module if_out_buf
  import if_fetch_unit_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                load_en,
  input  logic                clear_en,
  input  logic                consume_en,
  input  logic [PC_WIDTH-1:0] ir_d,
  input  logic [PC_WIDTH-1:0] pc_d,
  output logic                valid,
  output logic [PC_WIDTH-1:0] ir,
  output logic [PC_WIDTH-1:0] pc
);

  logic                valid_reg;
  logic [PC_WIDTH-1:0] ir_reg;
  logic [PC_WIDTH-1:0] pc_reg;

  // Buffer update: flush zeroes everything, a load overwrites, a transfer
  // only drops valid so the last word stays visible for debug.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_reg <= 1'b0;
      ir_reg    <= NOP_INSTR;
      pc_reg    <= NOP_INSTR;
    end else if (clear_en) begin
      valid_reg <= 1'b0;
      ir_reg    <= NOP_INSTR;
      pc_reg    <= NOP_INSTR;
    end else if (load_en) begin
      valid_reg <= 1'b1;
      ir_reg    <= ir_d;
      pc_reg    <= pc_d;
    end else if (consume_en) begin
      valid_reg <= 1'b0;
    end
  end

  assign valid = valid_reg;
  assign ir    = ir_reg;
  assign pc    = pc_reg;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs a single-outstanding-request
// instruction-memory handshake and feeds IF/ID through a one-entry buffer.
// Optional feature: define IF_STALL_CNT_EN to add stall_cnt_o, a free-running
// count of cycles where a valid instruction waits on ID (ready_i low).
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [PC_WIDTH-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [PC_WIDTH-1:0] PC_INC   = 32'd4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  output logic                imem_req_o,
  output logic [PC_WIDTH-1:0] imem_addr_o,
  input  logic                imem_ack_i,
  input  logic [PC_WIDTH-1:0] imem_data_i,
  input  logic                ready_i,
  input  logic                redirect_i,
  input  logic [PC_WIDTH-1:0] redirect_pc_i,
  output logic                valid_o,
  output logic [PC_WIDTH-1:0] IR_o,
  output logic [PC_WIDTH-1:0] PC_o
`ifdef IF_STALL_CNT_EN
  ,
  output logic [31:0]         stall_cnt_o
`endif
);

  fetch_state_t        state_reg;
  logic [PC_WIDTH-1:0] pc_reg;
  logic [PC_WIDTH-1:0] discard_addr_reg;
  logic                run_reg;

  logic                xfer;
  logic                req_fetch;
  logic                ack_fetch;
  logic [PC_WIDTH-1:0] pc_next_seq;
  logic [PC_WIDTH-1:0] redirect_target;

  assign xfer            = valid_o & ready_i;
  assign pc_next_seq     = pc_reg + PC_INC;
  assign redirect_target = align_pc(redirect_pc_i);

  // A new fetch may only be outstanding while the buffer can take its data.
  // run_reg keeps the request low until the first edge after reset release.
  assign req_fetch  = run_reg & (state_reg == FETCH) & (~valid_o | ready_i);
  assign ack_fetch  = req_fetch & imem_ack_i;
  assign imem_req_o = req_fetch | (state_reg == DISCARD);

  // DISCARD must keep presenting the abandoned address until it is acked
  assign imem_addr_o = (state_reg == DISCARD) ? discard_addr_reg : pc_reg;

  // Fetch FSM and PC; redirect overrides every other transition
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg        <= FETCH;
      pc_reg           <= RESET_PC;
      discard_addr_reg <= RESET_PC;
      run_reg          <= 1'b0;
    end else begin
      run_reg <= 1'b1;
      case (state_reg)
        FETCH: begin
          if (redirect_i) begin
            pc_reg <= redirect_target;
            if (req_fetch && !imem_ack_i) begin
              state_reg        <= DISCARD;
              discard_addr_reg <= pc_reg;
            end
          end else if (ack_fetch) begin
            pc_reg <= pc_next_seq;
          end else if (run_reg && valid_o && !ready_i) begin
            state_reg <= IDLE;
          end
        end
        IDLE: begin
          if (redirect_i) begin
            pc_reg    <= redirect_target;
            state_reg <= FETCH;
          end else if (xfer) begin
            state_reg <= FETCH;
          end
        end
        DISCARD: begin
          if (redirect_i) begin
            pc_reg <= redirect_target;
          end
          if (imem_ack_i) begin
            state_reg <= FETCH;
          end
        end
        default: state_reg <= FETCH;
      endcase
    end
  end

  if_out_buf u_out_buf (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_en    (ack_fetch & ~redirect_i),
    .clear_en   (redirect_i),
    .consume_en (xfer),
    .ir_d       (imem_data_i),
    .pc_d       (pc_next_seq),
    .valid      (valid_o),
    .ir         (IR_o),
    .pc         (PC_o)
  );

`ifdef IF_STALL_CNT_EN
  logic [31:0] stall_cnt_reg;

  // Count ID back-pressure cycles; survives redirects, wraps naturally
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_reg <= 32'd0;
    end else if (valid_o && !ready_i) begin
      stall_cnt_reg <= stall_cnt_reg + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios followed by a
// randomized phase, checked against a transaction-level model of the
// instruction stream the stage must hand to ID.
module tb_if_fetch_unit;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        imem_ack_i = 1'b0;
  logic [31:0] imem_data_i = 32'h0;
  logic        ready_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = 32'h0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        valid_o;
  logic [31:0] IR_o;
  logic [31:0] PC_o;
`ifdef IF_STALL_CNT_EN
  logic [31:0] stall_cnt_o;
  logic [31:0] stall_model;
`endif

  always #5 clk_i = ~clk_i;

  if_fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .PC_INC   (32'd4)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_ack_i    (imem_ack_i),
    .imem_data_i   (imem_data_i),
    .ready_i       (ready_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .valid_o       (valid_o),
    .IR_o          (IR_o),
    .PC_o          (PC_o)
`ifdef IF_STALL_CNT_EN
    ,
    .stall_cnt_o   (stall_cnt_o)
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  // Model: exp_pc is the address of the next instruction ID must receive
  logic [31:0] exp_pc;
  int          n_xfer;
  int          lat_mode;   // fixed ack latency, or -1 for random 0..3
  int          wait_cnt;   // memory-side cycles left before ack

  logic        s_req, s_valid;
  logic [31:0] s_addr;
  logic        prev_live, prev_req, prev_ack, prev_valid, prev_ready, prev_redirect;
  logic [31:0] prev_addr;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h5A5A_0000;
  endfunction

  function automatic int new_lat();
    if (lat_mode < 0) return int'($urandom_range(0, 3));
    return lat_mode;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Hold reset for two edges, checking outputs go idle at once
  task automatic do_reset();
    rst_i = 1'b0;
    imem_ack_i = 1'b0;
    redirect_i = 1'b0;
    #1;
    check("rst_req", 32'(imem_req_o), 32'd0);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_ir", IR_o, 32'h0);
    check("rst_pc", PC_o, 32'h0);
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    exp_pc = 32'h0;
    prev_live = 1'b0;
    wait_cnt = new_lat();
`ifdef IF_STALL_CNT_EN
    stall_model = 32'd0;
`endif
  endtask

  // One clock: memory responds, outputs are sampled at negedge and
  // checked against the model, then time advances past the next posedge.
  task automatic step();
    #1;
    if (imem_req_o) begin
      if (wait_cnt == 0) begin
        imem_ack_i  = 1'b1;
        imem_data_i = memfn(imem_addr_o);
      end else begin
        imem_ack_i  = 1'b0;
        imem_data_i = $urandom;
        wait_cnt--;
      end
    end else begin
      imem_ack_i = 1'b0;
      wait_cnt = new_lat();
    end
    @(negedge clk_i);
    s_req   = imem_req_o;
    s_addr  = imem_addr_o;
    s_valid = valid_o;
    if (prev_live) begin
      if (prev_redirect) begin
        check("flush_valid", 32'(s_valid), 32'd0);
        check("flush_ir", IR_o, 32'h0);
        check("flush_pc", PC_o, 32'h0);
      end else if (prev_valid && !prev_ready) begin
        check("stall_hold_valid", 32'(s_valid), 32'd1);
      end
      if (prev_req && !prev_ack) begin
        check("req_held", 32'(s_req), 32'd1);
        check("addr_stable", s_addr, prev_addr);
      end
    end
`ifdef IF_STALL_CNT_EN
    check("stall_cnt", stall_cnt_o, stall_model);
    if (s_valid && !ready_i) stall_model = stall_model + 32'd1;
`endif
    if (s_valid) begin
      check("buf_ir", IR_o, memfn(exp_pc));
      check("buf_pc", PC_o, exp_pc + 32'd4);
      if (ready_i) begin
        exp_pc = exp_pc + 32'd4;
        n_xfer++;
      end
    end
    if (redirect_i) exp_pc = redirect_pc_i & 32'hFFFF_FFFC;
    if (s_req && imem_ack_i) wait_cnt = new_lat();
    prev_live     = 1'b1;
    prev_req      = s_req;
    prev_ack      = imem_ack_i;
    prev_addr     = s_addr;
    prev_valid    = s_valid;
    prev_ready    = ready_i;
    prev_redirect = redirect_i;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    int found;
`ifdef IF_STALL_CNT_EN
    logic [31:0] st0;
`endif
    n_xfer = 0;
    lat_mode = 0;
    ready_i = 1'b1;
    prev_live = 1'b0;
    do_reset();

    // Back-to-back fetches, ack every cycle
    base = n_xfer;
    repeat (6) step();
    check("b2b_xfers", 32'(n_xfer - base >= 3), 32'd1);

    // Latency-3 memory
    lat_mode = 3;
    base = n_xfer;
    repeat (20) step();
    check("lat3_xfers", 32'(n_xfer - base >= 3), 32'd1);

    // Five-cycle ID stall with a full buffer
    lat_mode = 0;
    for (int i = 0; i < 12 && !valid_o; i++) step();
`ifdef IF_STALL_CNT_EN
    st0 = stall_cnt_o;
`endif
    ready_i = 1'b0;
    repeat (5) step();
    check("stall_req_low", 32'(s_req), 32'd0);
`ifdef IF_STALL_CNT_EN
    check("stall_cnt_5", stall_cnt_o - st0, 32'd5);
`endif
    ready_i = 1'b1;
    repeat (4) step();

    // Redirect while a latency-2 request to 0x10 is outstanding
    lat_mode = 2;
    redirect_pc_i = 32'h10;
    redirect_i = 1'b1;
    step();
    redirect_i = 1'b0;
    found = 0;
    for (int i = 0; i < 12; i++) begin
      if (imem_req_o && imem_addr_o == 32'h10 && wait_cnt > 0) begin
        found = 1;
        break;
      end
      step();
    end
    check("req_0x10_seen", 32'(found), 32'd1);
    redirect_pc_i = 32'h0000_0103;
    redirect_i = 1'b1;
    step();
    redirect_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (imem_req_o && imem_addr_o != 32'h10) break;
      step();
    end
    check("post_discard_addr", imem_addr_o, 32'h0000_0100);
    repeat (8) step();

    // Redirect coinciding with an ack and a transfer
    lat_mode = 0;
    for (int i = 0; i < 12 && !(valid_o && imem_req_o); i++) step();
    redirect_pc_i = 32'h200;
    redirect_i = 1'b1;
    base = n_xfer;
    step();
    redirect_i = 1'b0;
    check("redir_xfer_counted", 32'(n_xfer - base), 32'd1);
    repeat (5) step();

    // PC wrap at the top of the address space
    redirect_pc_i = 32'hFFFF_FFFE;
    redirect_i = 1'b1;
    step();
    redirect_i = 1'b0;
    found = 0;
    for (int i = 0; i < 12; i++) begin
      if (imem_req_o && imem_addr_o == 32'h0) begin
        found = 1;
        break;
      end
      step();
    end
    check("wrap_to_zero", 32'(found), 32'd1);
    repeat (4) step();

    // Asynchronous reset in the middle of a request
    lat_mode = 3;
    for (int i = 0; i < 12 && !(imem_req_o && wait_cnt > 0); i++) step();
    #3;
    do_reset();
    for (int i = 0; i < 6 && !imem_req_o; i++) step();
    check("post_rst_addr", imem_addr_o, 32'h0);
    repeat (10) step();

    // Randomized traffic
    lat_mode = -1;
    base = n_xfer;
    for (int i = 0; i < 3000; i++) begin
      ready_i    = ($urandom_range(0, 3) != 0);
      redirect_i = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 7) == 0)
        redirect_pc_i = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      else
        redirect_pc_i = $urandom;
      step();
    end
    redirect_i = 1'b0;
    check("random_progress", 32'(n_xfer - base >= 300), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
